// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and an
// opcode legality helper.
package cpu_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  // The full 7-bit compare also rejects words whose low two bits are not 2'b11.
  function automatic logic opc_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
      LUI, AUIPC, SYSTEM, MISC_MEM: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: classifies the opcode into an RV32I immediate format
// and produces the sign-extended immediate.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int XW = 32
) (
  input  logic [31:0]   i_instr,
  output logic [XW-1:0] o_imm,
  output imm_type_e     o_imm_type
);

  logic signed [31:0] w_imm32;

  always_comb begin
    case (i_instr[6:0])
      LOAD, OP_IMM, JALR: o_imm_type = IMM_I;
      STORE:              o_imm_type = IMM_S;
      BRANCH:             o_imm_type = IMM_B;
      LUI, AUIPC:         o_imm_type = IMM_U;
      JAL:                o_imm_type = IMM_J;
      default:            o_imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    case (o_imm_type)
      IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_instr[31:12], 12'h000};
      IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = 32'sd0;
    endcase
  end

  assign o_imm = XW'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready pipeline register, register-file address
// steering with same-edge writeback bypass, and immediate/control decode.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [31:0]   i_instr,
  input  logic [XW-1:0] i_pc,
  input  logic          i_flush,
  output logic [4:0]    o_rf_addr1,
  output logic [4:0]    o_rf_addr2,
  input  logic [XW-1:0] i_rf_data1,
  input  logic [XW-1:0] i_rf_data2,
  input  logic          i_wb_en,
  input  logic [4:0]    i_wb_addr,
  input  logic [XW-1:0] i_wb_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [XW-1:0] o_pc,
  output logic [31:0]   o_instr,
  output logic [XW-1:0] o_rs1_data,
  output logic [XW-1:0] o_rs2_data,
  output logic [XW-1:0] o_imm,
  output logic [4:0]    o_rd,
  output logic          o_rd_we,
  output logic          o_illegal
);

  logic          r_valid;
  logic [31:0]   r_instr;
  logic [XW-1:0] r_pc;
  logic          r_byp_hit1;
  logic          r_byp_hit2;
  logic [XW-1:0] r_byp_data1;
  logic [XW-1:0] r_byp_data2;

  logic          w_hold;
  logic          w_accept;
  imm_type_e     w_imm_type;

  assign w_hold   = r_valid & ~i_ready;
  assign o_ready  = ~r_valid | i_ready;
  assign w_accept = i_valid & o_ready;

  // Flush wins over a same-cycle accept, dropping the incoming word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= {XW{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Re-read the held sources while stalled so late writebacks are picked up.
  always_comb begin
    if (w_hold) begin
      o_rf_addr1 = r_instr[19:15];
      o_rf_addr2 = r_instr[24:20];
    end else begin
      o_rf_addr1 = i_instr[19:15];
      o_rf_addr2 = i_instr[24:20];
    end
  end

  // The file returns the old value on a same-edge write, so capture the write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byp_hit1  <= 1'b0;
      r_byp_hit2  <= 1'b0;
      r_byp_data1 <= {XW{1'b0}};
      r_byp_data2 <= {XW{1'b0}};
    end else begin
      r_byp_hit1  <= i_wb_en & (i_wb_addr != 5'd0) & (i_wb_addr == o_rf_addr1);
      r_byp_hit2  <= i_wb_en & (i_wb_addr != 5'd0) & (i_wb_addr == o_rf_addr2);
      r_byp_data1 <= i_wb_data;
      r_byp_data2 <= i_wb_data;
    end
  end

  assign o_rs1_data = r_byp_hit1 ? r_byp_data1 : i_rf_data1;
  assign o_rs2_data = r_byp_hit2 ? r_byp_data2 : i_rf_data2;

  imm_gen #(.XW(XW)) u_imm_gen (
    .i_instr    (r_instr),
    .o_imm      (o_imm),
    .o_imm_type (w_imm_type)
  );

  // I, U and J formats are exactly the rd-writing opcodes other than OP.
  assign o_valid   = r_valid;
  assign o_pc      = r_pc;
  assign o_instr   = r_instr;
  assign o_rd      = r_instr[11:7];
  assign o_rd_we   = (r_instr[11:7] != 5'd0) &
                     ((w_imm_type == IMM_I) | (w_imm_type == IMM_U) |
                      (w_imm_type == IMM_J) | (r_instr[6:0] == OP));
  assign o_illegal = (r_instr[1:0] != 2'b11) | ~opc_legal(r_instr[6:0]);

endmodule
